sram_ctrl: RTL and testbench

SRAM_CTRL -- requirements
Module: sram_ctrl

---
 rtl/sram_ctrl_pkg.sv | 19 +
 rtl/sram_rd_buf.sv | 38 +++
 rtl/sram_ctrl.sv | 130 +++++++++++++
 tb/tb_sram_ctrl.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_ctrl_pkg.sv
// Shared types and constants for the SRAM controller: FSM state encoding,
// default parameter values and external SRAM bus widths.
package sram_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LO   = 2'd1,
    HI   = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam int DEF_BASE_ADDR   = 1024;
  localparam int DEF_WAIT_CYCLES = 5;
  localparam int SRAM_DW         = 16;
  localparam int SRAM_AW         = 18;
  localparam int WORD_AW         = SRAM_AW - 1;
  localparam int CNT_W           = 4;

endpackage

// File: rtl/sram_rd_buf.sv
// One-entry last-read buffer (word address, data, valid) used when the
// controller is built with SRAM_RD_BYPASS_EN.
module sram_rd_buf
  import sram_ctrl_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               fill,
  input  logic [WORD_AW-1:0] fill_addr,
  input  logic [31:0]        fill_data,
  input  logic               clear,
  input  logic [WORD_AW-1:0] lookup_addr,
  output logic               hit,
  output logic [31:0]        data
);

  logic               valid;
  logic [WORD_AW-1:0] tag;
  logic [31:0]        store;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= 1'b0;
      tag   <= '0;
      store <= '0;
    end else if (clear) begin
      valid <= 1'b0;
    end else if (fill) begin
      valid <= 1'b1;
      tag   <= fill_addr;
      store <= fill_data;
    end
  end

  assign hit  = valid && (tag == lookup_addr);
  assign data = store;

endmodule

// File: rtl/sram_ctrl.sv
// Pipeline MEM-stage to 16-bit async SRAM bridge: each 32-bit access is split
// into a low and a high half-word phase. Optional read bypass: SRAM_RD_BYPASS_EN.
//
// state | meaning
// IDLE  | waiting for wr_en/rd_en; ready high only when no request
// LO    | low half-word access, WAIT_CYCLES cycles
// HI    | high half-word access, WAIT_CYCLES cycles
// DONE  | ready high for one cycle, then back to IDLE
module sram_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int BASE_ADDR   = DEF_BASE_ADDR,
  parameter int WAIT_CYCLES = DEF_WAIT_CYCLES
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wr_en,
  input  logic               rd_en,
  input  logic [31:0]        address,
  input  logic [31:0]        wdata,
  output logic [31:0]        rdata,
  output logic               ready,
  output logic [SRAM_AW-1:0] sram_addr,
  output logic [SRAM_DW-1:0] sram_dq_o,
  input  logic [SRAM_DW-1:0] sram_dq_i,
  output logic               sram_dq_oe,
  output logic               sram_we_n
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_CYCLES - 1);

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic [31:0]        rdata_q;
  logic [31:0]        offset;
  logic [WORD_AW-1:0] word_addr;
  logic               req, last;
  logic               hit;
  logic [31:0]        hit_data;
  logic               unused_bits;

  assign offset      = address - 32'(BASE_ADDR);
  assign word_addr   = offset[WORD_AW+1:2];
  assign unused_bits = ^{offset[31:WORD_AW+2], offset[1:0]};
  assign req         = wr_en | rd_en;
  assign last        = (cnt == CNT_LAST);

`ifdef SRAM_RD_BYPASS_EN
  logic buf_hit, buf_fill, buf_clear;

  assign buf_fill  = (state == HI) && last && !wr_en;
  assign buf_clear = (state == IDLE) && wr_en;

  sram_rd_buf u_rd_buf (
    .clk         (clk),
    .rst         (rst),
    .fill        (buf_fill),
    .fill_addr   (word_addr),
    .fill_data   ({sram_dq_i, rdata_q[15:0]}),
    .clear       (buf_clear),
    .lookup_addr (word_addr),
    .hit         (buf_hit),
    .data        (hit_data)
  );

  assign hit   = (state == IDLE) && rd_en && !wr_en && buf_hit;
  assign rdata = hit ? hit_data : rdata_q;
`else
  assign hit      = 1'b0;
  assign hit_data = '0;
  assign rdata    = rdata_q;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      rdata_q <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      // a bypass hit also counts as a read, so the held value follows it
      if (hit)
        rdata_q <= hit_data;
      else if ((state == LO) && last && !wr_en)
        rdata_q[15:0] <= sram_dq_i;
      else if ((state == HI) && last && !wr_en)
        rdata_q[31:16] <= sram_dq_i;
    end
  end

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    ready      = 1'b0;
    sram_addr  = '0;
    sram_dq_o  = '0;
    sram_dq_oe = 1'b0;
    sram_we_n  = 1'b1;
    case (state)
      IDLE: begin
        ready = !req || hit;
        if (req && !hit) begin
          state_nxt = LO;
          cnt_nxt   = '0;
        end
      end
      LO, HI: begin
        sram_addr = {word_addr, state == HI};
        if (wr_en) begin
          sram_we_n  = 1'b0;
          sram_dq_oe = 1'b1;
          sram_dq_o  = (state == HI) ? wdata[31:16] : wdata[15:0];
        end
        if (last) begin
          cnt_nxt   = '0;
          state_nxt = (state == LO) ? HI : DONE;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      DONE: begin
        ready     = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_sram_ctrl.sv
// Self-checking bench for sram_ctrl: SRAM device model, transaction-level
// reference model with per-cycle compare, directed and random requests.
module tb_sram_ctrl;

  localparam int BASE = 1024;
  localparam int W    = 5;
  localparam int DONE_C = 2 * W + 1;

  logic        clk;
  logic        rst;
  logic        wr_en, rd_en;
  logic [31:0] address, wdata, rdata;
  logic        ready;
  logic [17:0] sram_addr;
  logic [15:0] sram_dq_o, sram_dq_i;
  logic        sram_dq_oe, sram_we_n;

  int checks   = 0;
  int failures = 0;

  logic [15:0] sram_mem [0:262143];
  logic [31:0] ref_mem  [0:131071];

  logic [17:0] cap_addr1, cap_addr6;
  logic [15:0] cap_dq1, cap_dq6;
  logic        cap_we1;

  sram_ctrl #(.BASE_ADDR(BASE), .WAIT_CYCLES(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .wr_en      (wr_en),
    .rd_en      (rd_en),
    .address    (address),
    .wdata      (wdata),
    .rdata      (rdata),
    .ready      (ready),
    .sram_addr  (sram_addr),
    .sram_dq_o  (sram_dq_o),
    .sram_dq_i  (sram_dq_i),
    .sram_dq_oe (sram_dq_oe),
    .sram_we_n  (sram_we_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] f(int i);
    return 16'(i * 40503 + 17) ^ 16'h5A5A;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // SRAM device: asynchronous read, write on the clock while we_n is low
  assign sram_dq_i = sram_mem[sram_addr];
  initial begin
    for (int i = 0; i < 262144; i++) sram_mem[i] = f(i);
    forever begin
      @(posedge clk);
      if (!sram_we_n) sram_mem[sram_addr] = sram_dq_o;
    end
  end

  // Reference model: tracks cycles elapsed since a request was accepted
  initial begin : model
    int          m_c;
    int          cur;
    logic [31:0] m_rdata, off;
    logic [16:0] wa;
    logic        lo, hi, acc;
`ifdef SRAM_RD_BYPASS_EN
    logic        m_bv;
    logic [16:0] m_ba;
    logic [31:0] m_bd;
    m_bv = 1'b0; m_ba = '0; m_bd = '0;
`endif
    for (int w = 0; w < 131072; w++) ref_mem[w] = {f(2 * w + 1), f(2 * w)};
    m_c = -1;
    m_rdata = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        chk("rst_we_n", 32'(sram_we_n), 32'd1);
        chk("rst_oe", 32'(sram_dq_oe), 32'd0);
        chk("rst_addr", 32'(sram_addr), 32'd0);
        chk("rst_dq_o", 32'(sram_dq_o), 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        m_c = -1;
        m_rdata = '0;
`ifdef SRAM_RD_BYPASS_EN
        m_bv = 1'b0;
`endif
      end else begin
        off = address - 32'(BASE);
        wa  = off[18:2];
        cur = m_c;
        if (m_c < 0 && (wr_en || rd_en)) begin
          cur = 0;
`ifdef SRAM_RD_BYPASS_EN
          if (!wr_en && m_bv && m_ba == wa) begin
            cur = -1;
            m_rdata = m_bd;
          end
`endif
        end
        lo  = (cur >= 1) && (cur <= W);
        hi  = (cur > W) && (cur <= 2 * W);
        acc = lo || hi;
        if (cur == DONE_C && !wr_en) begin
          m_rdata = ref_mem[wa];
`ifdef SRAM_RD_BYPASS_EN
          m_bv = 1'b1; m_ba = wa; m_bd = ref_mem[wa];
`endif
        end
        chk("ready", 32'(ready), 32'((cur < 0) || (cur == DONE_C)));
        chk("sram_addr", 32'(sram_addr), acc ? 32'({wa, hi}) : 32'd0);
        chk("sram_we_n", 32'(sram_we_n), 32'(!(acc && wr_en)));
        chk("sram_dq_oe", 32'(sram_dq_oe), 32'(acc && wr_en));
        if (acc && wr_en)
          chk("sram_dq_o", 32'(sram_dq_o), lo ? 32'(wdata[15:0]) : 32'(wdata[31:16]));
        if (cur < 0 || cur == DONE_C)
          chk("rdata", rdata, m_rdata);
        if (cur == 0 && wr_en) begin
          ref_mem[wa] = wdata;
`ifdef SRAM_RD_BYPASS_EN
          m_bv = 1'b0;
`endif
        end
        m_c = (cur < 0 || cur == DONE_C) ? -1 : cur + 1;
      end
    end
  end

  task automatic do_req(input logic w, input logic r, input logic [31:0] a,
                        input logic [31:0] d, output int lat);
    @(posedge clk); #1;
    wr_en = w; rd_en = r; address = a; wdata = d;
    lat = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (i == 1) begin cap_addr1 = sram_addr; cap_dq1 = sram_dq_o; cap_we1 = sram_we_n; end
      if (i == W + 1) begin cap_addr6 = sram_addr; cap_dq6 = sram_dq_o; end
      if (ready) begin lat = i; break; end
    end
    if (lat < 0) begin
      checks++;
      failures++;
      $display("FAIL req_timeout actual=no_ready required=ready_within_40_cycles at %0t", $time);
    end
  endtask

  task automatic idle(input int n);
    @(posedge clk); #1;
    wr_en = 1'b0; rd_en = 1'b0;
    repeat (n) @(posedge clk);
  endtask

  initial begin
    int lat, lat2, wi, op;
    logic [31:0] a;
    rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; address = '0; wdata = '0;
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;
    @(negedge clk); #1;
    chk("post_reset_ready", 32'(ready), 32'd1);

    do_req(1'b1, 1'b0, 32'd1028, 32'hDEADBEEF, lat);
    chk("wr_latency", 32'(lat), 32'd11);
    chk("wr_lo_addr", 32'(cap_addr1), 32'd2);
    chk("wr_lo_data", 32'(cap_dq1), 32'hBEEF);
    chk("wr_hi_addr", 32'(cap_addr6), 32'd3);
    chk("wr_hi_data", 32'(cap_dq6), 32'hDEAD);
    idle(2);

    do_req(1'b0, 1'b1, 32'd1028, 32'h0, lat);
    chk("rd_latency", 32'(lat), 32'd11);
    chk("rd_data", rdata, 32'hDEADBEEF);
    idle(1);

    do_req(1'b0, 1'b1, 32'd1028, 32'h0, lat);
`ifdef SRAM_RD_BYPASS_EN
    chk("rd_repeat_latency", 32'(lat), 32'd0);
`else
    chk("rd_repeat_latency", 32'(lat), 32'd11);
`endif
    chk("rd_repeat_data", rdata, 32'hDEADBEEF);
    idle(1);
    do_req(1'b1, 1'b0, 32'd1028, 32'hCAFEF00D, lat);
    idle(1);
    do_req(1'b0, 1'b1, 32'd1028, 32'h0, lat);
    chk("rd_after_wr_latency", 32'(lat), 32'd11);
    chk("rd_after_wr_data", rdata, 32'hCAFEF00D);
    idle(2);

    do_req(1'b0, 1'b1, 32'd1024, 32'h0, lat);
    do_req(1'b0, 1'b1, 32'd1032, 32'h0, lat2);
    chk("b2b_first_latency", 32'(lat), 32'd11);
    chk("b2b_second_latency", 32'(lat2), 32'd11);
    chk("b2b_second_data", rdata, {f(5), f(4)});
    idle(1);

    do_req(1'b1, 1'b1, 32'd1040, 32'h12345678, lat);
    chk("both_latency", 32'(lat), 32'd11);
    chk("both_we_n", 32'(cap_we1), 32'd0);
    chk("both_rdata_held", rdata, {f(5), f(4)});
    idle(2);

    // reset during the third HI cycle of a write to an otherwise unused word
    @(posedge clk); #1;
    wr_en = 1'b1; rd_en = 1'b0; address = 32'(BASE + 400); wdata = 32'h0BAD0BAD;
    for (int i = 0; i <= W + 3; i++) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midrst_we_n", 32'(sram_we_n), 32'd1);
    chk("midrst_oe", 32'(sram_dq_oe), 32'd0);
    wr_en = 1'b0;
    @(negedge clk);
    #2 rst = 1'b0;
    @(negedge clk); #1;
    chk("midrst_ready", 32'(ready), 32'd1);
    chk("midrst_rdata", rdata, 32'd0);

    for (int n = 0; n < 80; n++) begin
      op = int'($urandom_range(0, 3));
      wi = int'($urandom_range(0, 17)) - 2;
      a  = 32'(BASE + 4 * wi) + 32'($urandom_range(0, 3));
      do_req(op == 0 || op == 2, op != 0, a, $urandom(), lat);
      if ($urandom_range(0, 2) == 0) idle(int'($urandom_range(1, 3)));
    end
    idle(3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
